// File: rtl/prelude_boot_ctrl.sv
// Host-facing run/load controller for the prelude core: decodes a byte command
// stream, loads instruction memory and gates core execution (run/halt/step/clear).
module prelude_boot_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    input  logic [7:0]        cmd_data,
    output logic              cmd_ready,
    output logic              rsp_valid,
    output logic [7:0]        rsp_data,
    input  logic              rsp_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_en,
    output logic              cpu_clear,
    input  logic [ADDR_W-1:0] cpu_pc
);

    localparam int CNT_W = ADDR_W + 1;

    localparam logic [7:0] CMD_LOAD  = 8'h4C;
    localparam logic [7:0] CMD_RUN   = 8'h52;
    localparam logic [7:0] CMD_HALT  = 8'h48;
    localparam logic [7:0] CMD_STEP  = 8'h53;
    localparam logic [7:0] CMD_PC    = 8'h50;
    localparam logic [7:0] CMD_CLEAR = 8'h43;

    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;
    localparam logic [7:0] RSP_UNK = 8'h3F;

    typedef enum logic [1:0] {
        IDLE,
        LEN,
        DATA,
        RESP
    } state_t;

    state_t           state;
    logic             run;
    logic             step_pulse;
    logic [CNT_W-1:0] count;

    logic             accept;
    logic [7:0]       pc_byte;
    logic [CNT_W-1:0] len_count;
    logic [7:0]       idle_rsp;

    assign accept = cmd_valid & cmd_ready;

    // PC readback is one byte wide regardless of the address width.
    generate
        if (ADDR_W >= 8) begin : g_pc_trunc
            assign pc_byte = cpu_pc[7:0];
        end else begin : g_pc_ext
            assign pc_byte = {{(8 - ADDR_W){1'b0}}, cpu_pc};
        end
    endgenerate

    // A length byte of zero means a full memory image.
    assign len_count = (cmd_data == 8'd0) ? {1'b1, {ADDR_W{1'b0}}} : CNT_W'(cmd_data);

    always_comb begin
        idle_rsp = RSP_UNK;
        case (cmd_data)
            CMD_RUN:   idle_rsp = RSP_ACK;
            CMD_HALT:  idle_rsp = RSP_ACK;
            CMD_STEP:  idle_rsp = run ? RSP_NAK : RSP_ACK;
            CMD_PC:    idle_rsp = pc_byte;
            CMD_CLEAR: idle_rsp = RSP_ACK;
            default:   idle_rsp = RSP_UNK;
        endcase
    end

    assign imem_we    = (state == DATA) & accept;
    assign imem_wdata = imem_we ? DATA_W'(cmd_data) : '0;

    // The core never advances while a load is in flight or while its PC is being cleared.
    assign cpu_en = (run | step_pulse) & ~cpu_clear & ((state == IDLE) | (state == RESP));

    // NOTE: all state here is updated with non-blocking assignments so every
    // decision below sees the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            run        <= 1'b0;
            step_pulse <= 1'b0;
            cpu_clear  <= 1'b0;
            cmd_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= 8'd0;
            imem_addr  <= '0;
            count      <= '0;
        end else begin
            step_pulse <= 1'b0;
            cpu_clear  <= 1'b0;
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (accept) begin
                        if (cmd_data == CMD_LOAD) begin
                            run   <= 1'b0;
                            state <= LEN;
                        end else begin
                            state     <= RESP;
                            cmd_ready <= 1'b0;
                            rsp_valid <= 1'b1;
                            rsp_data  <= idle_rsp;
                            case (cmd_data)
                                CMD_RUN:   run        <= 1'b1;
                                CMD_HALT:  run        <= 1'b0;
                                CMD_STEP:  step_pulse <= ~run;
                                CMD_CLEAR: cpu_clear  <= 1'b1;
                                default:   ;
                            endcase
                        end
                    end
                end
                LEN: begin
                    cmd_ready <= 1'b1;
                    if (accept) begin
                        count     <= len_count;
                        imem_addr <= '0;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    cmd_ready <= 1'b1;
                    if (accept) begin
                        imem_addr <= imem_addr + ADDR_W'(1);
                        count     <= count - CNT_W'(1);
                        if (count == CNT_W'(1)) begin
                            cpu_clear <= 1'b1;
                            state     <= RESP;
                            cmd_ready <= 1'b0;
                            rsp_valid <= 1'b1;
                            rsp_data  <= RSP_ACK;
                        end
                    end
                end
                RESP: begin
                    // Response drains before any new byte is taken.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        cmd_ready <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
